coriolis_ostream_sink: RTL and testbench

//  Consumer end of a kernel-node output stream (valid/ready, 34-bit FloPoCo FP words).

---
 rtl/coriolis_ostream_sink.sv | 183 ++++++++++++++++++
 tb/tb_coriolis_ostream_sink.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coriolis_ostream_sink.sv
// -----------------------------------------------------------------------------
// coriolis_ostream_sink
//
// Consumer end of a kernel-node output stream. Each accepted 34-bit FloPoCo
// word ({exn[1:0], sign, exp[7:0], frac[22:0]}) is converted to IEEE-754
// single precision and pushed into a show-ahead FIFO. The FIFO head is
// presented as a 32-bit valid/ready stream. Words are counted against a
// per-job length, and done pulses once the last word has left the FIFO.
//
// Ports
//   clk        in   clock
//   rst        in   synchronous reset, active-high
//   start      in   one-cycle job start pulse, honoured only when idle
//   n_elem     in   job length in words, latched on start
//   in_valid   in   upstream word valid
//   in_data    in   upstream FloPoCo word
//   in_ready   out  registered upstream ready
//   out_valid  out  FIFO not empty
//   out_data   out  IEEE-754 word at the FIFO head
//   out_ready  in   downstream accept
//   busy       out  a job is in progress (state != IDLE)
//   done       out  one-cycle job completion pulse
//   nan_seen   out  sticky: a NaN word was accepted in the current job
// -----------------------------------------------------------------------------
module coriolis_ostream_sink #(
    parameter int unsigned STREAMW      = 34,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned AFULL_MARGIN = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [31:0]        n_elem,
    input  logic               in_valid,
    input  logic [STREAMW-1:0] in_data,
    output logic               in_ready,
    output logic               out_valid,
    output logic [31:0]        out_data,
    input  logic               out_ready,
    output logic               busy,
    output logic               done,
    output logic               nan_seen
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FILL_LIMIT = CW'(DEPTH - AFULL_MARGIN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] fill_q, fill_d;
    logic [31:0]   rcvd_q, rcvd_d;
    logic [31:0]   nelem_q, nelem_d;
    logic          ready_q, ready_d;
    logic          nan_q, nan_d;
    logic [31:0]   mem_q [DEPTH];

    logic          wr;
    logic          rd;
    logic [1:0]    exn;
    logic [31:0]   conv_word;

    assign exn = in_data[STREAMW-1 -: 2];
    assign wr  = in_valid & ready_q;
    assign rd  = out_valid & out_ready;

    // FloPoCo -> IEEE-754. Sign sits at bit 31 of the payload in every class.
    always_comb begin
        conv_word = 32'h7FC0_0000;
        case (exn)
            2'b00:   conv_word = {in_data[31], 31'b0};
            2'b01:   conv_word = in_data[31:0];
            2'b10:   conv_word = {in_data[31], 8'hFF, 23'b0};
            default: conv_word = 32'h7FC0_0000;
        endcase
    end

    // Storage carries no reset; only the pointers and fill define contents.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem_q[wptr_q] <= conv_word;
        end
    end

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        fill_d  = fill_q;
        rcvd_d  = rcvd_q;
        nelem_d = nelem_q;
        nan_d   = nan_q;

        if (wr) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (rd) begin
            rptr_d = rptr_q + AW'(1);
        end
        case ({wr, rd})
            2'b10:   fill_d = fill_q + CW'(1);
            2'b01:   fill_d = fill_q - CW'(1);
            default: fill_d = fill_q;
        endcase

        if (wr) begin
            rcvd_d = rcvd_q + 32'd1;
            if (exn == 2'b11) begin
                nan_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    nelem_d = n_elem;
                    rcvd_d  = '0;
                    nan_d   = 1'b0;
                    state_d = (n_elem != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (wr && (rcvd_d == nelem_q)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Leave as soon as the last word is being read out.
                if ((fill_q == '0) || ((fill_q == CW'(1)) && rd)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Registered ready looks at next-cycle fill, so the margin absorbs
        // the one-cycle lag and the FIFO can never be written when full.
        ready_d = (state_d == S_RUN) && (fill_d < FILL_LIMIT) && (rcvd_d != nelem_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            fill_q  <= '0;
            rcvd_q  <= '0;
            nelem_q <= '0;
            ready_q <= 1'b0;
            nan_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            fill_q  <= fill_d;
            rcvd_q  <= rcvd_d;
            nelem_q <= nelem_d;
            ready_q <= ready_d;
            nan_q   <= nan_d;
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = (fill_q != '0);
    assign out_data  = mem_q[rptr_q];
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign nan_seen  = nan_q;

endmodule

// File: tb/tb_coriolis_ostream_sink.sv
// -----------------------------------------------------------------------------
// tb_coriolis_ostream_sink
//
// Bench for coriolis_ostream_sink. A job-level model (queue of converted
// words, received count, job-active / done flags) predicts every output each
// cycle; directed jobs add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_coriolis_ostream_sink;

    localparam int DEPTH  = 16;
    localparam int MARGIN = 2;
    localparam int LIMIT  = DEPTH - MARGIN;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] n_elem = '0;
    logic        in_valid = 1'b0;
    logic [33:0] in_data = '0;
    logic        out_ready = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        busy;
    logic        done;
    logic        nan_seen;

    coriolis_ostream_sink #(
        .STREAMW      (34),
        .DEPTH        (DEPTH),
        .AFULL_MARGIN (MARGIN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .n_elem    (n_elem),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .nan_seen  (nan_seen)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model state: represents the DUT after the next rising edge once updated.
    logic [31:0] m_q [$];
    bit          m_job   = 1'b0;
    bit          m_done  = 1'b0;
    bit          m_ready = 1'b0;
    bit          m_nan   = 1'b0;
    bit          m_wr    = 1'b0;
    int unsigned m_rcvd  = 0;
    int unsigned m_n     = 0;

    int          done_cnt   = 0;
    int          dut_wr_cnt = 0;
    int          stall_acc  = 0;
    logic [31:0] got_q [$];
    logic [33:0] stim  [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] conv(input logic [33:0] w);
        case (w[33:32])
            2'b00:   return {w[31], 31'b0};
            2'b01:   return w[31:0];
            2'b10:   return {w[31], 8'hFF, 23'b0};
            default: return 32'h7FC0_0000;
        endcase
    endfunction

    // Compare, then advance the model with the inputs that the next edge sees.
    always @(negedge clk) begin
        bit rd;
        bit was_done;
        bit all_in;
        chk("in_ready", in_ready, m_ready);
        chk("out_valid", out_valid, m_q.size() != 0);
        if (m_q.size() != 0) chk("out_data", out_data, m_q[0]);
        chk("busy", busy, m_job || m_done);
        chk("done", done, m_done);
        chk("nan_seen", nan_seen, m_nan);
        chk("no_overflow", in_valid && in_ready && (m_q.size() >= DEPTH), 1'b0);

        if (done === 1'b1) done_cnt++;
        if (out_valid === 1'b1 && out_ready) got_q.push_back(out_data);
        if (in_valid && in_ready === 1'b1) dut_wr_cnt++;

        m_wr = !rst && in_valid && m_ready;
        rd   = (m_q.size() != 0) && out_ready;
        if (rst) begin
            m_q.delete();
            m_job = 0; m_done = 0; m_ready = 0; m_nan = 0;
            m_rcvd = 0; m_n = 0; m_wr = 0;
        end else begin
            was_done = m_done;
            m_done   = 0;
            if (!m_job && !was_done) begin
                if (start) begin
                    m_n    = n_elem;
                    m_rcvd = 0;
                    m_nan  = 0;
                    if (n_elem == 0) m_done = 1;
                    else             m_job  = 1;
                end
            end else if (m_job) begin
                all_in = (m_rcvd == m_n);
                if (rd) void'(m_q.pop_front());
                if (m_wr) begin
                    m_q.push_back(conv(in_data));
                    m_rcvd++;
                    if (in_data[33:32] == 2'b11) m_nan = 1;
                end
                if (all_in && m_q.size() == 0) begin
                    m_job  = 0;
                    m_done = 1;
                end
            end
            m_ready = m_job && (m_q.size() < LIMIT) && (m_rcvd != m_n);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Runs one job from stim[]; out_ready held low for the first `stall` cycles.
    task automatic run_job(input int unsigned n, input int vpct, input int rpct,
                           input int stall, input int budget);
        int unsigned idx = 0;
        int d0 = done_cnt;
        int w0 = dut_wr_cnt;
        int t = 0;
        got_q.delete();
        start = 1'b1; n_elem = n; in_valid = 1'b0; out_ready = 1'b0;
        cyc();
        start = 1'b0;
        while (done_cnt == d0 && t < budget) begin
            if (m_wr) idx++;
            if (t == stall) stall_acc = dut_wr_cnt - w0;
            if (idx < n) begin
                in_valid = ($urandom_range(99) < vpct);
                in_data  = stim[idx];
            end else begin
                in_valid = 1'b1;
                in_data  = {2'($urandom), $urandom};
            end
            out_ready = (t < stall) ? 1'b0 : ($urandom_range(99) < rpct);
            cyc();
            t++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("job_completed", done_cnt > d0, 1'b1);
        chk("words_fed", idx, n);
    endtask

    task automatic check_drained_stream(input string nm);
        chk({nm, "_count"}, got_q.size(), stim.size());
        for (int i = 0; i < stim.size() && i < got_q.size(); i++)
            chk({nm, "_word"}, got_q[i], conv(stim[i]));
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : stimulus
        logic [31:0] t1_exp [4];
        logic [31:0] t2_exp [3];
        int d0;
        int unsigned idx;
        t1_exp = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
        t2_exp = '{32'h8000_0000, 32'h7F80_0000, 32'h7FC0_0000};

        repeat (3) cyc();
        chk("reset_busy", busy, 1'b0);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_in_ready", in_ready, 1'b0);
        rst = 1'b0;
        cyc();

        // T1: plain numeric words, full throughput.
        stim.delete();
        for (int i = 0; i < 4; i++) stim.push_back({2'b01, t1_exp[i]});
        d0 = done_cnt;
        run_job(4, 100, 100, 0, 100);
        chk("t1_count", got_q.size(), 4);
        for (int i = 0; i < 4 && i < got_q.size(); i++) chk("t1_word", got_q[i], t1_exp[i]);
        cyc();
        chk("t1_done_once", done_cnt - d0, 1);
        chk("t1_busy_after", busy, 1'b0);

        // T2: zero, infinity, NaN.
        stim.delete();
        stim.push_back({2'b00, 32'h8123_4567});
        stim.push_back({2'b10, 32'h0ABC_DEF0});
        stim.push_back({2'b11, 32'h0000_0001});
        run_job(3, 100, 100, 0, 100);
        chk("t2_count", got_q.size(), 3);
        for (int i = 0; i < 3 && i < got_q.size(); i++) chk("t2_word", got_q[i], t2_exp[i]);
        repeat (3) cyc();
        chk("t2_nan_sticky", nan_seen, 1'b1);

        // T4: empty job.
        start = 1'b1; n_elem = 0;
        cyc();
        start = 1'b0;
        chk("t4_busy", busy, 1'b1);
        chk("t4_done", done, 1'b1);
        chk("t4_nan_cleared", nan_seen, 1'b0);
        cyc();
        chk("t4_busy_after", busy, 1'b0);
        chk("t4_done_after", done, 1'b0);

        // T3: downstream stalled, upstream always valid.
        stim.delete();
        for (int i = 0; i < 20; i++) stim.push_back({2'b01, 32'h4100_0000 + i});
        run_job(20, 100, 100, 30, 400);
        chk("t3_accepted_while_stalled", stall_acc, LIMIT);
        check_drained_stream("t3");

        // T5: random traffic, long job.
        stim.delete();
        for (int i = 0; i < 1000; i++) stim.push_back({2'($urandom_range(3)), $urandom});
        run_job(1000, 60, 50, 0, 20000);
        check_drained_stream("t5");
        repeat (2) cyc();

        // T6: reset in the middle of a job, then a normal job.
        stim.delete();
        for (int i = 0; i < 10; i++) stim.push_back({(i == 2) ? 2'b11 : 2'b01, 32'h3F00_0000 + i});
        d0 = done_cnt;
        start = 1'b1; n_elem = 10;
        cyc();
        start = 1'b0;
        idx = 0;
        for (int t = 0; t < 50 && m_rcvd < 5; t++) begin
            if (m_wr) idx++;
            in_valid  = 1'b1;
            in_data   = stim[idx];
            out_ready = (t % 3 == 0);
            cyc();
        end
        chk("t6_reached_word5", m_rcvd, 5);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        cyc();
        rst = 1'b0;
        chk("t6_in_ready", in_ready, 1'b0);
        chk("t6_out_valid", out_valid, 1'b0);
        chk("t6_busy", busy, 1'b0);
        chk("t6_done", done, 1'b0);
        chk("t6_nan_seen", nan_seen, 1'b0);
        repeat (3) cyc();
        chk("t6_no_done", done_cnt - d0, 0);
        stim.delete();
        for (int i = 0; i < 3; i++) stim.push_back({2'b01, 32'hC000_0000 + i});
        run_job(3, 80, 80, 0, 200);
        check_drained_stream("t6_after");
        repeat (2) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
